// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared constants for the second-generation ALU control:
//   - ALUop encodings driven by the main control
//   - R-type function codes (instruction bits [5:0])
//   - alu_ctr operation select codes for the main ALU
//   - state enum of the multiply/divide sequencer
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

    // ALUop encodings from the main control
    localparam logic [2:0] OP_ANDI  = 3'b000;
    localparam logic [2:0] OP_ORI   = 3'b001;
    localparam logic [2:0] OP_RSV2  = 3'b010;
    localparam logic [2:0] OP_RSV3  = 3'b011;
    localparam logic [2:0] OP_SLTI  = 3'b100;
    localparam logic [2:0] OP_ADDI  = 3'b101;
    localparam logic [2:0] OP_SUBI  = 3'b110;
    localparam logic [2:0] OP_RTYPE = 3'b111;

    // R-type function codes
    localparam logic [5:0] FN_ADD  = 6'b000010;
    localparam logic [5:0] FN_SUB  = 6'b000011;
    localparam logic [5:0] FN_AND  = 6'b000100;
    localparam logic [5:0] FN_OR   = 6'b000101;
    localparam logic [5:0] FN_SLT  = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    // alu_ctr operation select codes
    localparam logic [2:0] CTR_AND  = 3'b000;
    localparam logic [2:0] CTR_OR   = 3'b001;
    localparam logic [2:0] CTR_SLT  = 3'b100;
    localparam logic [2:0] CTR_ADD  = 3'b101;
    localparam logic [2:0] CTR_SUB  = 3'b110;
    localparam logic [2:0] CTR_NONE = 3'b111;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // True for the function codes served by the mult/div sequencer
    function automatic logic is_md_fn(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_DIV);
    endfunction

endpackage

// File: rtl/md_iter_unit.sv
// -----------------------------------------------------------------------------
// md_iter_unit
// WIDTH-parametrised iterative unsigned multiply / divide datapath.
//   multiply : shift-add, one multiplier bit per cycle, WIDTH cycles
//   divide   : restoring division, one quotient bit per cycle, WIDTH cycles
//   divide by zero finishes in its first cycle with lo = all-ones, hi = dividend
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   start                load operands and begin (one-cycle strobe)
//   op_div               0 = multiply, 1 = divide (sampled with start)
//   operand_a/operand_b  multiplicand/dividend and multiplier/divisor
//   done                 final iteration is executing this cycle
//   res_hi/res_lo        result; valid while done is high
// -----------------------------------------------------------------------------
module md_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             run_r;
    logic             div_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    // Multiply: hi_r = partial product, lo_r = multiplier shifting out / product low.
    // Divide:   hi_r = partial remainder, lo_r = dividend shifting out / quotient.
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH-1:0] div_diff_s;
    logic             div_fit_s;
    logic             div_zero_s;
    logic             last_s;

    // One multiply step: conditional add then shift the 2*WIDTH+1 accumulator right
    always_comb begin
        if (lo_r[0]) begin
            mul_sum_s = {1'b0, hi_r} + {1'b0, a_r};
        end else begin
            mul_sum_s = {1'b0, hi_r};
        end
    end

    // One restoring divide step; the difference only matters when it fits, so
    // the WIDTH-bit modular subtraction is exact in that case
    always_comb begin
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_fit_s   = (div_shift_s >= {1'b0, b_r});
        div_diff_s  = div_shift_s[WIDTH-1:0] - b_r;
    end

    assign div_zero_s = (b_r == {WIDTH{1'b0}});
    assign last_s     = (cnt_r == CNT_W'(WIDTH - 1));

    // Select next accumulator value for the running operation and flag completion
    always_comb begin
        if (div_r && div_zero_s) begin
            res_hi = a_r;
            res_lo = {WIDTH{1'b1}};
        end else if (div_r) begin
            res_hi = div_fit_s ? div_diff_s : div_shift_s[WIDTH-1:0];
            res_lo = {lo_r[WIDTH-2:0], div_fit_s};
        end else begin
            res_hi = mul_sum_s[WIDTH:1];
            res_lo = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
        done = run_r && (last_s || (div_r && div_zero_s));
    end

    // Operand capture and iteration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            run_r <= 1'b0;
            div_r <= 1'b0;
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            hi_r  <= {WIDTH{1'b0}};
            lo_r  <= {WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (start) begin
            run_r <= 1'b1;
            div_r <= op_div;
            a_r   <= operand_a;
            b_r   <= operand_b;
            hi_r  <= {WIDTH{1'b0}};
            lo_r  <= op_div ? operand_a : operand_b;
            cnt_r <= {CNT_W{1'b0}};
        end else if (run_r) begin
            hi_r  <= res_hi;
            lo_r  <= res_lo;
            cnt_r <= cnt_r + CNT_W'(1);
            run_r <= ~done;
        end else begin
            run_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_ctrl_md.sv
// -----------------------------------------------------------------------------
// alu_ctrl_md
// ALU control with combinational alu_ctr decode plus an iterative unsigned
// mult/div sequencer and HI/LO result registers.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   instr_valid     current instruction is valid
//   ALUop           3-bit op class from main control
//   function_code   instruction bits [5:0]
//   operand_a/_b    rs / rt values
//   alu_ctr         ALU operation select (combinational)
//   stall           hold PC/instruction while the sequencer is busy
//   md_done         one-cycle pulse when hi/lo are updated
//   hi, lo          product upper/lower half, or remainder/quotient
//   illegal         unrecognised ALUop/function, gated by instr_valid
// -----------------------------------------------------------------------------
module alu_ctrl_md
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [2:0]       ALUop,
    input  logic [5:0]       function_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [2:0]       alu_ctr,
    output logic             stall,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             illegal
);

    logic [2:0] ctr_s;
    logic       ill_raw_s;
    logic       md_req_s;

    // ALUop / function decode; mult/div are illegal when the sequencer is absent
    always_comb begin
        ctr_s     = CTR_NONE;
        ill_raw_s = 1'b0;
        case (ALUop)
            OP_ANDI:  ctr_s = CTR_AND;
            OP_ORI:   ctr_s = CTR_OR;
            OP_SLTI:  ctr_s = CTR_SLT;
            OP_ADDI:  ctr_s = CTR_ADD;
            OP_SUBI:  ctr_s = CTR_SUB;
            OP_RTYPE: begin
                case (function_code)
                    FN_ADD:  ctr_s = CTR_ADD;
                    FN_SUB:  ctr_s = CTR_SUB;
                    FN_AND:  ctr_s = CTR_AND;
                    FN_OR:   ctr_s = CTR_OR;
                    FN_SLT:  ctr_s = CTR_SLT;
                    FN_JR:   ctr_s = CTR_NONE;
                    FN_MULT, FN_DIV: begin
                        ctr_s     = CTR_NONE;
                        ill_raw_s = ~MD_EN;
                    end
                    default: begin
                        ctr_s     = CTR_NONE;
                        ill_raw_s = 1'b1;
                    end
                endcase
            end
            default: begin
                ctr_s     = CTR_NONE;
                ill_raw_s = 1'b1;
            end
        endcase
    end

    assign alu_ctr  = ctr_s;
    assign illegal  = instr_valid & ill_raw_s;
    assign md_req_s = MD_EN && instr_valid && (ALUop == OP_RTYPE) && is_md_fn(function_code);

    generate
        if (MD_EN) begin : g_md
            md_state_e        state_r;
            logic             md_done_r;
            logic [WIDTH-1:0] hi_r;
            logic [WIDTH-1:0] lo_r;
            logic             accept_s;
            logic             unit_done_s;
            logic [WIDTH-1:0] res_hi_s;
            logic [WIDTH-1:0] res_lo_s;

            // A request is only taken from IDLE; the held instruction seen in
            // DONE therefore cannot restart the sequencer
            assign accept_s = (state_r == ST_IDLE) && md_req_s;

            md_iter_unit #(
                .WIDTH (WIDTH)
            ) u_iter (
                .clk       (clk),
                .reset     (reset),
                .start     (accept_s),
                .op_div    (function_code == FN_DIV),
                .operand_a (operand_a),
                .operand_b (operand_b),
                .done      (unit_done_s),
                .res_hi    (res_hi_s),
                .res_lo    (res_lo_s)
            );

            // Sequencer FSM with HI/LO result registers and done pulse
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_r   <= ST_IDLE;
                    md_done_r <= 1'b0;
                    hi_r      <= {WIDTH{1'b0}};
                    lo_r      <= {WIDTH{1'b0}};
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            md_done_r <= 1'b0;
                            if (accept_s) begin
                                state_r <= (function_code == FN_DIV) ? ST_DIV : ST_MUL;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end
                        ST_MUL, ST_DIV: begin
                            if (unit_done_s) begin
                                hi_r      <= res_hi_s;
                                lo_r      <= res_lo_s;
                                md_done_r <= 1'b1;
                                state_r   <= ST_DONE;
                            end else begin
                                md_done_r <= 1'b0;
                            end
                        end
                        ST_DONE: begin
                            md_done_r <= 1'b0;
                            state_r   <= ST_IDLE;
                        end
                        default: begin
                            md_done_r <= 1'b0;
                            state_r   <= ST_IDLE;
                        end
                    endcase
                end
            end

            // Stall covers the accept cycle combinationally, then the busy states
            assign stall   = accept_s || (state_r == ST_MUL) || (state_r == ST_DIV);
            assign md_done = md_done_r;
            assign hi      = hi_r;
            assign lo      = lo_r;
        end else begin : g_no_md
            assign stall   = 1'b0;
            assign md_done = 1'b0;
            assign hi      = {WIDTH{1'b0}};
            assign lo      = {WIDTH{1'b0}};
        end
    endgenerate

endmodule

// File: doc/alu_ctrl_md.md
Name: alu_ctrl_md

Overview:
Second-generation ALU control for the single-cycle datapath. It keeps the combinational 3-bit alu_ctr decode and adds a parametrised iterative multiply/divide sequencer (mult/div R-type) with HI/LO result registers. While a mult/div is running it stalls the PC/pipeline. It sits beside the main ALU and is driven by the main control's ALUop and the instruction's function field.

Parameters:
WIDTH, 32, operand and HI/LO register width (>=4)
MD_EN, 1, 1 = mult/div implemented; 0 = mult/div decode as illegal, sequencer removed

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
instr_valid  in  1  current instruction is valid this cycle
ALUop  in  3  from main control
function_code  in  6  instruction bits [5:0]
operand_a  in  WIDTH  rs value (multiplicand / dividend)
operand_b  in  WIDTH  rt value (multiplier / divisor)
alu_ctr  out  3  ALU operation select
stall  out  1  hold PC and instruction; high while the sequencer is busy
md_done  out  1  one-cycle pulse when HI/LO are updated
hi  out  WIDTH  product upper half / remainder
lo  out  WIDTH  product lower half / quotient
illegal  out  1  unrecognised ALUop/function combination

Behaviour:
- Reset is synchronous and active-high: stall=0, md_done=0, hi=0, lo=0, FSM=IDLE, counter=0.
- ALUop 000 andi->000; 001 ori->001; 100 slti->100; 101 addi/lw/sw/lb/sb->101; 110 subi/beq/bne->110; 111 R-type (decode function_code); 010/011 -> alu_ctr=111, illegal=1.
- R-type: 000010 add->101; 000011 sub->110; 000100 and->000; 000101 or->001; 000111 slt->100; 001000 jr->111; 011000 mult->111; 011010 div->111; any other code -> 111 with illegal=1.
- alu_ctr and illegal are purely combinational and independent of the FSM. illegal is gated by instr_valid.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE -> MUL/DIV when instr_valid & R-type & mult/div & MD_EN. Operands are latched on that edge. stall is a combinational 1 in the accept cycle so the PC holds.
- MUL: unsigned shift-add, one multiplier bit per cycle, WIDTH cycles.
- DIV: unsigned restoring division, one quotient bit per cycle, WIDTH cycles.
- Divide by zero: DIV takes 1 cycle and gives lo = all-ones, hi = dividend.
- Counter width is $clog2(WIDTH+1). The iteration ends when the counter reaches WIDTH-1.
- DONE: hi/lo are written and md_done=1 for exactly one cycle, and stall=0. The FSM then returns to IDLE.
- The held instruction is still presented during DONE. The FSM must not re-accept it: DONE always returns to IDLE, and the PC advances at the end of DONE.
- Latency: accept at cycle 0; hi/lo are valid and md_done=1 at cycle WIDTH+1 (div-by-zero: cycle 2). stall is high from cycle 0 through cycle WIDTH.
- hi/lo hold their values until the next mult/div completes. An aborted op never updates them.
- Requests in MUL/DIV/DONE are ignored.
- reset mid-operation: immediate return to IDLE. hi/lo are cleared, and no md_done pulse is produced.
- MD_EN=0: stall is tied to 0 and hi/lo are tied to 0.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALUop constants (OP_ANDI..OP_RTYPE)
  - function codes (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR, FN_MULT, FN_DIV)
  - alu_ctr codes (CTR_AND=000, CTR_OR=001, CTR_SLT=100, CTR_ADD=101, CTR_SUB=110, CTR_NONE=111)
  - the FSM state enum
- One sub-module, md_iter_unit: the WIDTH-parametrised shift-add/restoring datapath with start/op/done, no decode. alu_ctrl_md holds the decode, FSM control and HI/LO registers.

Test Plan:
- Decode sweep, all ALUop values and R-type codes with instr_valid=1 -> alu_ctr matches the table. Checks: add=101, slt=100, jr=111, func 100000 -> illegal=1, ALUop 010 -> illegal=1.
- WIDTH=8 mult 200*100 -> stall high cycles 0-8; cycle 9: md_done=1, hi=0x4E, lo=0x20; cycle 10: md_done=0 and state returns to IDLE.
- WIDTH=8 div 200/7 -> cycle 9: lo=28, hi=4, md_done=1. WIDTH=32 div 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0 at cycle 33.
- WIDTH=8 div 0x55/0 -> cycle 2: lo=0xFF, hi=0x55, md_done=1; stall high only in cycles 0-1.
- Start mult 3*5, then assert reset at cycle 4 -> next cycle stall=0, hi=lo=0, and no md_done afterwards. A new mult 3*5 then gives lo=15 at cycle 9.
- Back-to-back mult then add: the held mult instruction gives a single md_done. The add issues with alu_ctr=101 and stall=0, and hi/lo are unchanged.
